// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with held redirect and perf counters
//
// Purpose: turns back-end busy, load-use, fetch-busy and EX redirects into
// per-stage-register enable/flush strobes and PC-update controls. A redirect
// that arrives while a fetch is in flight is parked in held_pc until the
// fetch returns.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   imem_busy, dmem_busy        fetch / data access outstanding
//   ex_busy                     multi-cycle EX unit not done
//   load_use                    load-use hazard between ID and EX
//   redirect_valid/redirect_pc  EX-resolved redirect and its target
//   en_pc, pc_sel, pc_target    PC register enable, mux select, mux target
//   en_d/e/m/w, flush_d/e/m/w   stage register enables and synchronous clears
//   stall_cnt, redir_cnt        cycles with en_pc=0, accepted redirects
module pipe_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             ex_busy,
  input  logic             load_use,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             en_pc,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic {RUN, HOLD_REDIR} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] held_pc;
  logic            redir_take;  // redirect accepted this cycle (counted)
  logic            held_load;   // capture redirect_pc into held_pc

  always_comb begin
    en_pc      = 1'b1;
    en_d       = 1'b1;
    en_e       = 1'b1;
    en_m       = 1'b1;
    en_w       = 1'b1;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_m    = 1'b0;
    flush_w    = 1'b0;
    pc_sel     = 1'b0;
    pc_target  = (state == HOLD_REDIR) ? held_pc : redirect_pc;
    redir_take = 1'b0;
    held_load  = 1'b0;
    state_nxt  = state;

    if (reset) begin
      en_pc   = 1'b0;
      en_d    = 1'b0;
      en_e    = 1'b0;
      en_m    = 1'b0;
      en_w    = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else if (state == RUN) begin
      if (dmem_busy) begin
        en_pc   = 1'b0;
        en_d    = 1'b0;
        en_e    = 1'b0;
        en_m    = 1'b0;
        flush_w = 1'b1;
      end else if (ex_busy) begin
        en_pc   = 1'b0;
        en_d    = 1'b0;
        en_e    = 1'b0;
        flush_m = 1'b1;
      end else if (redirect_valid) begin
        // Redirect beats load_use: the dependent ID instruction is squashed anyway.
        flush_d    = 1'b1;
        flush_e    = 1'b1;
        redir_take = 1'b1;
        if (imem_busy) begin
          en_pc     = 1'b0;
          held_load = 1'b1;
          state_nxt = HOLD_REDIR;
        end else begin
          pc_sel = 1'b1;
        end
      end else if (load_use) begin
        en_pc   = 1'b0;
        en_d    = 1'b0;
        flush_e = 1'b1;
      end else if (imem_busy) begin
        en_pc   = 1'b0;
        flush_d = 1'b1;
      end
    end else begin
      // The fetch in flight belongs to the wrong path; drop it at F/D every cycle.
      flush_d = 1'b1;
      if (dmem_busy) begin
        en_d    = 1'b0;
        en_e    = 1'b0;
        en_m    = 1'b0;
        flush_w = 1'b1;
      end else if (ex_busy) begin
        en_d    = 1'b0;
        en_e    = 1'b0;
        flush_m = 1'b1;
      end
      if (!imem_busy && !dmem_busy) begin
        pc_sel    = 1'b1;
        state_nxt = RUN;
      end else begin
        en_pc = 1'b0;
      end
      if (redirect_valid && !dmem_busy && !ex_busy) begin
        redir_take = 1'b1;
        held_load  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      held_pc   <= '0;
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (held_load)  held_pc   <= redirect_pc;
      if (!en_pc)     stall_cnt <= stall_cnt + 1'b1;
      if (redir_take) redir_cnt <= redir_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a cycle reference model
module tb_pipe_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, imem_busy, dmem_busy, ex_busy, load_use, redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             en_pc, pc_sel, en_d, en_e, en_m, en_w;
  logic             flush_d, flush_e, flush_m, flush_w;
  logic [XLEN-1:0]  pc_target;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit               m_hold;
  logic [XLEN-1:0]  m_held;
  logic [CNT_W-1:0] m_stall, m_redir;

  pipe_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .ex_busy(ex_busy), .load_use(load_use), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .en_pc(en_pc), .pc_sel(pc_sel), .pc_target(pc_target),
    .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare against the model,
  // then advance the model across the rising edge.
  task automatic step(input bit r, input bit im, input bit dm, input bit ex,
                      input bit lu, input bit rv, input logic [63:0] rpc);
    logic [3:0]      e_en, e_fl;   // {d,e,m,w}
    bit              e_pcen, e_sel, take, n_hold;
    logic [XLEN-1:0] n_held;
    @(negedge clk);
    reset = r; imem_busy = im; dmem_busy = dm; ex_busy = ex;
    load_use = lu; redirect_valid = rv; redirect_pc = rpc;
    #1;
    e_en = 4'b1111; e_fl = 4'b0000; e_pcen = 1; e_sel = 0; take = 0;
    n_hold = m_hold; n_held = m_held;
    if (r) begin
      e_en = 4'b0000; e_fl = 4'b1111; e_pcen = 0;
    end else if (!m_hold) begin
      if (dm)      begin e_pcen = 0; e_en = 4'b0001; e_fl = 4'b0001; end
      else if (ex) begin e_pcen = 0; e_en = 4'b0011; e_fl = 4'b0010; end
      else if (rv) begin
        take = 1; e_fl = 4'b1100;
        if (im) begin e_pcen = 0; n_hold = 1; n_held = rpc; end
        else e_sel = 1;
      end
      else if (lu) begin e_pcen = 0; e_en = 4'b0111; e_fl = 4'b0100; end
      else if (im) begin e_pcen = 0; e_fl = 4'b1000; end
    end else begin
      e_fl = 4'b1000;
      if (dm)      begin e_en = 4'b0001; e_fl = 4'b1001; end
      else if (ex) begin e_en = 4'b0011; e_fl = 4'b1010; end
      if (!im && !dm) begin e_sel = 1; n_hold = 0; end
      else e_pcen = 0;
      if (rv && !dm && !ex) begin take = 1; n_held = rpc; end
    end
    check("en_pc", en_pc, e_pcen);
    check("pc_sel", pc_sel, e_sel);
    check("en_demw", {en_d, en_e, en_m, en_w}, e_en);
    check("flush_demw", {flush_d, flush_e, flush_m, flush_w}, e_fl);
    if (!r) begin
      check("pc_target", pc_target, m_hold ? m_held : rpc);
      check("stall_cnt", stall_cnt, m_stall);
      check("redir_cnt", redir_cnt, m_redir);
    end
    @(posedge clk);
    if (r) begin
      m_hold = 0; m_held = '0; m_stall = '0; m_redir = '0;
    end else begin
      if (!e_pcen) m_stall = m_stall + 1'b1;
      if (take)    m_redir = m_redir + 1'b1;
      m_hold = n_hold; m_held = n_held;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 64'h0);
  endtask

  initial begin
    m_hold = 0; m_held = '0; m_stall = '0; m_redir = '0;
    reset = 1; imem_busy = 0; dmem_busy = 0; ex_busy = 0;
    load_use = 0; redirect_valid = 0; redirect_pc = '0;
    step(1, 0, 0, 0, 0, 0, 64'h0);
    step(1, 0, 0, 0, 0, 0, 64'h0);
    #1;
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_redir_cnt", redir_cnt, 0);

    // load-use bubble, then free flow
    step(0, 0, 0, 0, 1, 0, 64'h0);
    idle();
    // redirect with the fetch idle
    step(0, 0, 0, 0, 0, 1, 64'h8000_0100);
    idle();
    // redirect with a fetch in flight, released three cycles later
    step(0, 1, 0, 0, 0, 1, 64'h8000_0200);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 64'h0);
    step(0, 0, 0, 0, 0, 0, 64'h0);
    idle();
    // dmem_busy + ex_busy + pending redirect, then acceptance
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 1, 64'h8000_0300);
    step(0, 0, 0, 0, 0, 1, 64'h8000_0300);
    idle();
    // multi-cycle EX stall
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 0, 64'h0);
    idle();
    // load_use together with imem_busy
    step(0, 1, 0, 0, 1, 0, 64'h0);
    // reset in the middle of HOLD_REDIR
    step(0, 1, 0, 0, 0, 1, 64'h8000_0400);
    step(0, 1, 0, 0, 0, 0, 64'h0);
    step(1, 1, 0, 0, 0, 0, 64'h0);
    step(0, 0, 0, 0, 0, 1, 64'h8000_0500);
    idle();

    // counter wrap: 2^CNT_W stalls bring stall_cnt back to 0
    step(1, 0, 0, 0, 0, 0, 64'h0);
    for (int i = 0; i < (1 << CNT_W); i++) step(0, 0, 0, 0, 1, 0, 64'h0);
    #1;
    check("stall_wrap", stall_cnt, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 40), ($urandom_range(99) < 15),
           ($urandom_range(99) < 15), ($urandom_range(99) < 20), ($urandom_range(99) < 25),
           {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
